// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU byte-stream controller and its ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, ALU opcode values, default widths.
package alu_pkg;

  localparam int N_BITS_DEF  = 8;
  localparam int OP_BITS_DEF = 6;

  // Controller sequence states; encoding is fixed so it can be probed in debug.
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } state_t;

  // Opcodes understood by the ALU; anything else returns 0.
  localparam logic [OP_BITS_DEF-1:0] OP_ADD = 6'h1C;
  localparam logic [OP_BITS_DEF-1:0] OP_SUB = 6'h1D;
  localparam logic [OP_BITS_DEF-1:0] OP_AND = 6'h1E;
  localparam logic [OP_BITS_DEF-1:0] OP_OR  = 6'h1F;

endpackage

// File: rtl/alu_ctrl_timeout.sv
// Inter-byte watchdog: counts enabled cycles, flags the terminal count.
// Latency: tc is combinational from the count register (CYCLES enabled clocks after clear).
// Backpressure: none; clear has priority over counting, count holds at terminal value.
// Ports: i_clk, i_rst_n (async active-low), i_en (count enable), i_clr (sync clear),
//        o_tc (high while enabled and count == CYCLES-1).
module alu_ctrl_timeout #(
  parameter int unsigned CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  assign o_tc = i_en && (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en && !o_tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer: collects A, B, opcode bytes from RX, drives the ALU, returns one result byte on TX.
// Latency: opcode handshake -> o_tx_valid in 2 clocks (EXEC, then SEND).
// Backpressure: o_rx_ready low in EXEC/SEND; result held in SEND until i_tx_ready.
// Ports: i_clk, i_rst_n (async active-low); RX stream i_rx_data/i_rx_valid/o_rx_ready;
//        TX stream o_tx_data/o_tx_valid/i_tx_ready; ALU side o_alu_a/o_alu_b/o_alu_op/i_alu_res;
//        status o_busy (not idle), o_err (timeout abort pulse).
// Build option: ALU_CTRL_TIMEOUT_EN enables the inter-byte timeout in WAIT_B/WAIT_OP.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int          N_BITS         = N_BITS_DEF,
  parameter int          OP_BITS        = OP_BITS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_BITS-1:0]  i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  output logic [N_BITS-1:0]  o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [N_BITS-1:0]  o_alu_a,
  output logic [N_BITS-1:0]  o_alu_b,
  output logic [OP_BITS-1:0] o_alu_op,
  input  logic [N_BITS-1:0]  i_alu_res,
  output logic               o_busy,
  output logic               o_err
);

  state_t            state;
  logic [N_BITS-1:0] a_q, b_q, res_q;
  logic [OP_BITS-1:0] op_q;
  logic              rx_ready_q, tx_valid_q, busy_q;
  logic              rx_hs, tx_hs;

  // Handshakes use only registered ready/valid, so there is no valid->ready path.
  assign rx_hs = i_rx_valid && rx_ready_q;
  assign tx_hs = tx_valid_q && i_tx_ready;

  assign o_rx_ready = rx_ready_q;
  assign o_tx_valid = tx_valid_q;
  assign o_tx_data  = res_q;
  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_busy     = busy_q;

`ifdef ALU_CTRL_TIMEOUT_EN
  logic timeout_hit;
  logic err_q;
  logic waiting;

  // Only a partially collected sequence is watched; idle and SEND may wait forever.
  assign waiting = (state == WAIT_B) || (state == WAIT_OP);
  assign o_err   = err_q;

  alu_ctrl_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (waiting),
    .i_clr   (rx_hs || !waiting),
    .o_tc    (timeout_hit)
  );
`else
  assign o_err = 1'b0;
`endif

  // Outputs are registered alongside the state so they reflect the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
`ifdef ALU_CTRL_TIMEOUT_EN
      err_q <= 1'b0;
      // A byte arriving on the terminal cycle wins over the abort.
      if (timeout_hit && !rx_hs) begin
        state      <= WAIT_A;
        a_q        <= '0;
        b_q        <= '0;
        op_q       <= '0;
        rx_ready_q <= 1'b1;
        busy_q     <= 1'b0;
        err_q      <= 1'b1;
      end else
`endif
      begin
        case (state)
          WAIT_A: begin
            // Also raises ready on the first edge after reset.
            rx_ready_q <= 1'b1;
            if (rx_hs) begin
              a_q    <= i_rx_data;
              state  <= WAIT_B;
              busy_q <= 1'b1;
            end
          end
          WAIT_B: begin
            if (rx_hs) begin
              b_q   <= i_rx_data;
              state <= WAIT_OP;
            end
          end
          WAIT_OP: begin
            if (rx_hs) begin
              op_q       <= i_rx_data[OP_BITS-1:0];
              state      <= EXEC;
              rx_ready_q <= 1'b0;
            end
          end
          EXEC: begin
            // ALU inputs have been stable since the opcode latch.
            res_q      <= i_alu_res;
            state      <= SEND;
            tx_valid_q <= 1'b1;
          end
          SEND: begin
            if (tx_hs) begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              state      <= WAIT_A;
            end
          end
          default: begin
            state      <= WAIT_A;
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Sequencer that feeds the combinational ALU from a byte-stream source (UART RX side) and returns the result to a byte-stream sink (UART TX side).
- Collects operand A, operand B and opcode as three consecutive bytes, drives the ALU, registers the result and emits it as one byte.
- Sits between the UART receiver/transmitter and the ALU instance in the top level.

Parameters:
- N_BITS, 8, data width of operands, result and stream bytes.
- OP_BITS, 6, opcode width driven to the ALU; taken from byte bits [OP_BITS-1:0]; OP_BITS <= N_BITS.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clocks (used only with ALU_CTRL_TIMEOUT_EN).

Ports:
- i_clk  in  1  system clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_data  in  N_BITS  incoming byte.
- i_rx_valid  in  1  incoming byte valid.
- o_rx_ready  out  1  controller accepts byte this cycle.
- o_tx_data  out  N_BITS  result byte.
- o_tx_valid  out  1  result byte valid.
- i_tx_ready  in  1  sink accepts byte this cycle.
- o_alu_a  out  N_BITS  operand A to ALU.
- o_alu_b  out  N_BITS  operand B to ALU.
- o_alu_op  out  OP_BITS  opcode to ALU.
- i_alu_res  in  N_BITS  ALU result (combinational).
- o_busy  out  1  high whenever state != WAIT_A.
- o_err  out  1  one-cycle pulse on timeout abort (0 when feature is off).

Behaviour:
- Reset (async assert, sync release):
  - State is WAIT_A; A/B/OP/result registers are 0.
  - o_tx_valid=0, o_rx_ready=0 during reset and 1 after the first post-reset edge, o_busy=0, o_err=0.
- Transfers complete on a clock edge with valid && ready high; no combinational valid-to-ready path.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_A, WAIT_B, WAIT_OP: o_rx_ready=1.
  - On RX handshake, latch the byte into A or B, or latch byte[OP_BITS-1:0] into OP.
  - Then advance to WAIT_B, WAIT_OP or EXEC respectively.
- EXEC: o_rx_ready=0; exactly one cycle; register i_alu_res into the result register; go to SEND.
- SEND: o_tx_valid=1, o_tx_data=result.
  - Hold data stable until i_tx_ready.
  - On TX handshake, deassert o_tx_valid next cycle and return to WAIT_A.
- o_alu_a/b/op are direct register outputs; they change only on RX latch and hold their last values otherwise.
- Latency: last (opcode) handshake to o_tx_valid=1 is 2 clocks (EXEC, then SEND).
- Back-to-back: the byte for the next A may be accepted in the cycle after the TX handshake, never the same cycle.
- RX bytes offered during EXEC/SEND are not accepted (ready=0); the source must hold them.
- Opcode is passed through unchecked; undefined opcodes yield whatever the ALU returns (0 for the current ALU).
- Reset mid-sequence discards partial operands and any pending result; no TX byte is emitted.
- Width: result is N_BITS, carry is dropped (wrap-around is the ALU's behaviour, not altered here).

Optional Feature:
- Macro: ALU_CTRL_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_B and WAIT_OP, cleared on every RX handshake and on entry to those states.
  - When it reaches TIMEOUT_CYCLES-1, go to WAIT_A, pulse o_err for 1 cycle, and clear A/B/OP.
  - The counter does not run in WAIT_A, EXEC or SEND; SEND may stall indefinitely.
- Not defined: no counter logic; o_err tied to 0; partial sequences wait forever.

Decomposition:
- Shared package alu_pkg:
  - State encoding typedef (3-bit enum WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SEND=4).
  - Opcode constants used by ALU and bench (OP_ADD=6'h1C, ...).
  - Default N_BITS/OP_BITS.
- Optional sub-module alu_ctrl_timeout: load/clear counter with terminal-count pulse, instantiated only under ALU_CTRL_TIMEOUT_EN.
- FSM and registers stay in alu_ctrl; the ALU is instantiated at top level, not inside.

Test Plan:
- Reset then bytes 0x05, 0x03, 0x1C with tx_ready=1 -> o_alu_op=0x1C; o_tx_data=0x08 with o_tx_valid exactly 2 clocks after the opcode handshake; o_busy low again after TX.
- Bytes 0xF0, 0x20, 0x1C -> o_tx_data=0x10 (wrap, carry dropped).
- Bytes 0x05, 0x03, 0x3F (undefined op) -> o_tx_data=0x00.
- Hold i_tx_ready=0 for 20 cycles in SEND while RX offers 0xAA -> o_tx_valid and data held stable, o_rx_ready=0, 0xAA accepted as A only after the TX handshake.
- Assert i_rst_n=0 after two bytes (0x11, 0x22), release, then send 0x01, 0x02, 0x1C -> o_tx_data=0x03; no stray TX from the aborted sequence.
- With ALU_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 0x07, then idle 16 cycles -> o_err pulses once, state WAIT_A; next triple 0x02, 0x02, 0x1C -> 0x04. Without the macro, the same idle leaves o_busy=1 and o_err=0.
